// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the hazard/forwarding controller.
//   FWD_*        : operand-mux select encoding driven into the EX stage
//   fsm_state_e  : controller sequencing states (RUN, LU_STALL, HOLD)
//   shadow_t     : one shadow-scoreboard entry {valid, dst, reg_write, mem_read}
//   entry_match  : "this entry will write register r", register 0 excluded
package pipe_pkg;

  localparam int SHADOW_AW = 5;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    HOLD     = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic                 valid;
    logic [SHADOW_AW-1:0] dst;
    logic                 reg_write;
    logic                 mem_read;
  } shadow_t;

  // Register 0 is hardwired zero, so it never names a real producer.
  function automatic logic entry_match(input shadow_t e, input logic [SHADOW_AW-1:0] r);
    return e.valid & e.reg_write & (e.dst == r) & (r != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: bundles the ID-stage instruction description, the
// pipeline control inputs and the controller's outputs.
//   master : pipeline side (drives id_*, flush_ex, ex_busy; reads selects/stalls)
//   slave  : controller side (hazard_fwd_ctrl)
interface hazard_fwd_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush_ex;
  logic              ex_busy;
  logic [1:0]        ALU_SrcA_fwd;
  logic [1:0]        ALU_SrcB_fwd;
  logic              stall_if_id;
  logic              bubble_ex;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read,
           flush_ex, ex_busy,
    input  ALU_SrcA_fwd, ALU_SrcB_fwd, stall_if_id, bubble_ex, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read,
           flush_ex, ex_busy,
    output ALU_SrcA_fwd, ALU_SrcB_fwd, stall_if_id, bubble_ex, stall_cnt
  );
endinterface

// File: rtl/fwd_select.sv
// fwd_select: combinational forwarding-source picker for one operand.
//   ex_e, mem_e : shadow entries of the instructions currently in EX and MEM
//   src         : source register read by the instruction in ID
//   enable      : operand really is read from the register file
//   sel         : FWD_MEM / FWD_WB / FWD_REG for the next EX cycle
module fwd_select
  import pipe_pkg::*;
(
  input  shadow_t              ex_e,
  input  shadow_t              mem_e,
  input  logic [SHADOW_AW-1:0] src,
  input  logic                 enable,
  output logic [1:0]           sel
);

  // The EX producer is checked first so the youngest write wins. A load in
  // EX cannot forward yet; that case is resolved by the load-use stall.
  always_comb begin
    sel = FWD_REG;
    if (enable) begin
      if (entry_match(ex_e, src) && !ex_e.mem_read) begin
        sel = FWD_MEM;
      end else if (entry_match(mem_e, src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: EX-stage operand forwarding and stall sequencing for a
// 5-stage pipeline.
//   clk, rst : pipeline clock (rising edge), asynchronous active-high reset
//   bus      : hazard_fwd_ctrl_if.slave
//              in : id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write,
//                   id_mem_read, flush_ex, ex_busy
//              out: ALU_SrcA_fwd, ALU_SrcB_fwd (registered), stall_if_id,
//                   bubble_ex (combinational), stall_cnt (saturating)
// A shadow copy of the EX and MEM destination registers is kept so the
// selects for the instruction entering EX can be registered one cycle early.
module hazard_fwd_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             rst,
  hazard_fwd_ctrl_if.slave bus
);

  fsm_state_e       state_q, state_d;
  shadow_t          ex_q, ex_d;
  shadow_t          mem_q, mem_d;
  logic [1:0]       sel_a_q, sel_a_d;
  logic [1:0]       sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [REG_AW-1:0] rs_w, rt_w;
  logic [1:0]        fwd_a, fwd_b;
  logic              lu;
  logic              stall;
  logic              bubble;

  assign rs_w = bus.id_rs;
  assign rt_w = bus.id_rt;

  fwd_select u_sel_a (
    .ex_e   (ex_q),
    .mem_e  (mem_q),
    .src    (rs_w),
    .enable (bus.id_valid),
    .sel    (fwd_a)
  );

  fwd_select u_sel_b (
    .ex_e   (ex_q),
    .mem_e  (mem_q),
    .src    (rt_w),
    .enable (bus.id_valid & bus.id_uses_rt),
    .sel    (fwd_b)
  );

  // A load in EX whose result the ID instruction needs cannot be forwarded
  // in time, so one bubble is inserted.
  assign lu = bus.id_valid & ex_q.mem_read &
              (entry_match(ex_q, rs_w) | (bus.id_uses_rt & entry_match(ex_q, rt_w)));

  // Next-state and control decode. Busy freezes everything, a flush squashes
  // the ID instruction (and overrides any load-use stall), a load-use hazard
  // drains EX into MEM behind a bubble, otherwise the pipeline advances.
  // HOLD and LU_STALL always fall back to RUN once their cause is gone.
  always_comb begin
    state_d = RUN;
    ex_d    = ex_q;
    mem_d   = mem_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    stall   = 1'b0;
    bubble  = 1'b0;

    if (bus.ex_busy) begin
      state_d = HOLD;
      stall   = 1'b1;
    end else if (bus.flush_ex) begin
      bubble  = 1'b1;
      mem_d   = ex_q;
      ex_d    = '0;
      sel_a_d = FWD_REG;
      sel_b_d = FWD_REG;
    end else if (lu) begin
      stall   = 1'b1;
      bubble  = 1'b1;
      mem_d   = ex_q;
      ex_d    = '0;
      sel_a_d = FWD_REG;
      sel_b_d = FWD_REG;
      if (state_q == RUN) begin
        state_d = LU_STALL;
      end
    end else begin
      mem_d           = ex_q;
      ex_d.valid      = bus.id_valid;
      ex_d.dst        = bus.id_dst;
      ex_d.reg_write  = bus.id_reg_write;
      ex_d.mem_read   = bus.id_mem_read;
      sel_a_d         = fwd_a;
      sel_b_d         = fwd_b;
    end
  end

  // Stall-cycle counter sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State, shadow scoreboard, registered selects and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      sel_a_q <= FWD_REG;
      sel_b_q <= FWD_REG;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall and bubble are forced low while reset is held, since the inputs
  // may still show a hazard against the shadow state being cleared.
  assign bus.stall_if_id  = stall & ~rst;
  assign bus.bubble_ex    = bubble & ~rst;
  assign bus.ALU_SrcA_fwd = sel_a_q;
  assign bus.ALU_SrcB_fwd = sel_b_q;
  assign bus.stall_cnt    = cnt_q;

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Sequences the 5-stage pipeline's EX-stage operand selection and stalls. Keeps a shadow scoreboard of the destination registers in EX and MEM. From it the block produces registered forwarding selects (ALU_SrcA_fwd, ALU_SrcB_fwd) for the instruction entering EX. It also detects load-use hazards, inserts one bubble, and freezes on a multi-cycle EX-unit busy. Sits beside the ID/EX pipeline register and drives the EX stage operand muxes.

Parameters:
REG_AW, 5, register-specifier width (32 GPRs, register 0 hardwired zero)
CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous reset, active-high
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_AW  source A register of ID instruction
id_rt  input  REG_AW  source B register of ID instruction (only checked when id_uses_rt=1)
id_uses_rt  input  1  ID instruction reads rt as ALU operand B (B-mux select 0)
id_dst  input  REG_AW  destination register of ID instruction
id_reg_write  input  1  ID instruction writes id_dst
id_mem_read  input  1  ID instruction is a load
flush_ex  input  1  branch/jump taken in EX: squash ID instruction
ex_busy  input  1  multi-cycle EX unit busy: freeze whole pipeline
ALU_SrcA_fwd  output  2  operand A select for EX: 0 regfile, 1 Fwd_wb, 2 Fwd_mem (registered)
ALU_SrcB_fwd  output  2  operand B select for EX, same encoding (registered)
stall_if_id  output  1  hold PC and IF/ID register (combinational)
bubble_ex  output  1  load ID/EX with a NOP (combinational)
stall_cnt  output  CNT_W  cycles spent in load-use stall or hold, saturating

Behaviour:
- Shadow entries ex_e and mem_e each hold {valid, dst, reg_write, mem_read}. Reset clears all fields to 0.
- Reset values: ALU_SrcA_fwd = ALU_SrcB_fwd = 0, stall_cnt = 0, FSM = RUN. stall_if_id and bubble_ex are 0 while rst is high.
- match(e, r) = e.valid & e.reg_write & (e.dst == r) & (r != 0). Register 0 is never forwarded and never causes a stall.
- Load-use hazard lu = id_valid & ex_e.mem_read & (match(ex_e, id_rs) | (id_uses_rt & match(ex_e, id_rt))).
- FSM states:
  - RUN: the normal state.
  - LU_STALL: exactly one cycle; entered when lu=1 in RUN. The next edge always returns to RUN, because the bubble clears ex_e.
  - HOLD: entered from any state whenever ex_busy=1. Stays there while ex_busy=1 and returns to RUN on the first cycle ex_busy=0.
- Priority per cycle: ex_busy > flush_ex > lu > normal advance.
- ex_busy=1:
  - stall_if_id=1, bubble_ex=0.
  - Shadow entries and forward selects hold their values; flush_ex is ignored.
  - stall_cnt increments.
- flush_ex=1 (ex_busy=0):
  - stall_if_id=0, bubble_ex=1, no stall even if lu=1.
  - Edge: mem_e<=ex_e, ex_e<=0, selects<=0.
- lu=1 (no busy/flush):
  - stall_if_id=1, bubble_ex=1, stall_cnt increments.
  - Edge: mem_e<=ex_e, ex_e<=0, selects<=0.
- Normal advance:
  - Edge: mem_e<=ex_e, ex_e<={id_valid, id_dst, id_reg_write, id_mem_read}.
  - Selects are computed from the pre-edge shadow:
    - If match(ex_e, src) & !ex_e.mem_read, select = 2 (producer will be in MEM).
    - Else if match(mem_e, src), select = 1 (producer will be in WB).
    - Else select = 0.
  - EX beats MEM when both match: the youngest producer wins.
  - ALU_SrcB_fwd is forced to 0 when id_uses_rt=0.
  - ALU_SrcA_fwd and ALU_SrcB_fwd are both forced to 0 when id_valid=0.
- Producers already in WB while the consumer is in ID are handled by the register file's write-before-read. This block never reports them.
- After a load-use stall, the load sits in mem_e, so the consumer's select is 1 (Fwd_wb).
- stall_cnt saturates at all-ones and does not wrap.
- Reset mid-stall or mid-hold returns immediately to RUN with cleared shadow entries.

Decomposition:
- Shared package pipe_pkg:
  - FWD_REG=2'd0, FWD_WB=2'd1, FWD_MEM=2'd2
  - FSM state encoding (RUN, LU_STALL, HOLD)
  - shadow-entry struct/field widths
- One natural sub-module: fwd_select. It is combinational and instantiated twice (rs, rt). Inputs: ex_e, mem_e, src, enable. Output: 2-bit select.

Test Plan:
- ALU r3<-r1+r2, then ALU r4<-r3+r5 (id_uses_rt=1) -> on the consumer's EX cycle ALU_SrcA_fwd=2, ALU_SrcB_fwd=0, no stall.
- Producer r3, one independent instruction, then consumer reads r3 as rt -> ALU_SrcB_fwd=1; repeat with producers writing r3 in both EX and MEM -> select=2 (youngest wins).
- Load r6, then consumer reads r6 as rs -> stall_if_id=1 and bubble_ex=1 for exactly one cycle; then ALU_SrcA_fwd=1; stall_cnt advances 0->1.
- Load r6 followed by consumer of r6 with flush_ex=1 in the same cycle -> stall_if_id=0, bubble_ex=1, selects 0, stall_cnt unchanged.
- ex_busy held high 4 cycles during a pending forward (ALU_SrcA_fwd=2) -> stall_if_id=1 for those 4 cycles, ALU_SrcA_fwd stays 2, stall_cnt +4; writes to r0 never produce a non-zero select.
- Assert rst mid LU_STALL -> all outputs 0 immediately; after release, a consumer of the pre-reset load's register gets select 0; force stall_cnt to 2^CNT_W-1 and stall -> it stays at max.
